// File: rtl/sync_adder.sv
// Registered N-bit unsigned adder built as a carry-select chain of ripple-carry blocks.
// Sum and carry are captured on the rising clock edge; synchronous active-high reset.

module sync_adder_ripple #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic carry;

    // NOTE: blocking assignments in always_comb let the loop carry ripple bit to bit
    // within one evaluation; non-blocking here would read stale values.
    always_comb begin
        carry = cin;
        s     = '0;
        for (int i = 0; i < W; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

module sync_adder #(
    parameter int N     = 29,
    parameter int BLOCK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    output logic [N-1:0] sum,
    output logic         carry_out
);

    localparam int NB = (N + BLOCK - 1) / BLOCK;

    logic [N-1:0] sel_sum;
    logic         sel_carry;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        localparam int LO = g * BLOCK;
        localparam int W  = (N - LO < BLOCK) ? (N - LO) : BLOCK;

        // Carry leaving this block after selection; each block keeps its own so the
        // chain stays a plain wire path rather than a self-referencing vector.
        logic c_sel;

        if (g == 0) begin : g_plain
            logic [W-1:0] s;
            logic         c;

            sync_adder_ripple #(.W(W)) u_rca (
                .a    (input1[LO +: W]),
                .b    (input2[LO +: W]),
                .cin  (1'b0),
                .s    (s),
                .cout (c)
            );

            assign sel_sum[LO +: W] = s;
            assign c_sel            = c;
        end else begin : g_select
            logic [W-1:0] s0, s1;
            logic         c0, c1;

            sync_adder_ripple #(.W(W)) u_rca0 (
                .a    (input1[LO +: W]),
                .b    (input2[LO +: W]),
                .cin  (1'b0),
                .s    (s0),
                .cout (c0)
            );

            sync_adder_ripple #(.W(W)) u_rca1 (
                .a    (input1[LO +: W]),
                .b    (input2[LO +: W]),
                .cin  (1'b1),
                .s    (s1),
                .cout (c1)
            );

            assign sel_sum[LO +: W] = g_blk[g-1].c_sel ? s1 : s0;
            assign c_sel            = g_blk[g-1].c_sel ? c1 : c0;
        end
    end

    assign sel_carry = g_blk[NB-1].c_sel;

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            sum       <= sel_sum;
            carry_out <= sel_carry;
        end
    end

endmodule

// File: tb/tb_sync_adder.sv
// Directed bench for sync_adder: reset, table of bit-run vectors across several
// BLOCK sizes, latency/hold behaviour, mid-stream reset and an exhaustive 8-bit sweep.

module tb_sync_adder;

    typedef struct {
        logic [28:0] a;
        logic [28:0] b;
        logic [28:0] s;
        logic        c;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [28:0] input1, input2;
    logic [28:0] sum, sum_b1, sum_b4, sum_b29;
    logic        carry_out, c_b1, c_b4, c_b29;
    logic [7:0]  a8, b8, s8;
    logic        c8;

    int passed = 0;
    int total  = 0;
    int toggles = 0;
    logic watch = 1'b0;

    vec_t vecs[20];

    always #5 clk = ~clk;

    sync_adder #(.N(29), .BLOCK(8)) dut (
        .clk(clk), .rst(rst), .input1(input1), .input2(input2),
        .sum(sum), .carry_out(carry_out));

    sync_adder #(.N(29), .BLOCK(1)) dut_b1 (
        .clk(clk), .rst(rst), .input1(input1), .input2(input2),
        .sum(sum_b1), .carry_out(c_b1));

    sync_adder #(.N(29), .BLOCK(4)) dut_b4 (
        .clk(clk), .rst(rst), .input1(input1), .input2(input2),
        .sum(sum_b4), .carry_out(c_b4));

    sync_adder #(.N(29), .BLOCK(29)) dut_b29 (
        .clk(clk), .rst(rst), .input1(input1), .input2(input2),
        .sum(sum_b29), .carry_out(c_b29));

    sync_adder #(.N(8), .BLOCK(3)) dut_n8 (
        .clk(clk), .rst(rst), .input1(a8), .input2(b8),
        .sum(s8), .carry_out(c8));

    always @(sum or carry_out) if (watch) toggles++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic check_all(input string name, input logic [28:0] es, input logic ec);
        check({name, " b8"},  {carry_out, sum},   {ec, es});
        check({name, " b1"},  {c_b1, sum_b1},     {ec, es});
        check({name, " b4"},  {c_b4, sum_b4},     {ec, es});
        check({name, " b29"}, {c_b29, sum_b29},   {ec, es});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [28:0] prev_s;
        logic        prev_c;
        int          bad;

        vecs[0]  = '{29'h0000000,  29'h1FFFF800, 29'h1FFFF800, 1'b0};
        vecs[1]  = '{29'h1FFFFFFF, 29'h00007FFF, 29'h00007FFE, 1'b1};
        vecs[2]  = '{29'h1FFFFFFF, 29'h00000001, 29'h00000000, 1'b1};
        vecs[3]  = '{29'h0FFFFFFF, 29'h00000001, 29'h10000000, 1'b0};
        vecs[4]  = '{29'h00000000, 29'h00000000, 29'h00000000, 1'b0};
        vecs[5]  = '{29'h1FFFFFFF, 29'h1FFFFFFF, 29'h1FFFFFFE, 1'b1};
        vecs[6]  = '{29'h000000FF, 29'h00000001, 29'h00000100, 1'b0};
        vecs[7]  = '{29'h0000FFFF, 29'h00000001, 29'h00010000, 1'b0};
        vecs[8]  = '{29'h00FFFFFF, 29'h00000001, 29'h01000000, 1'b0};
        vecs[9]  = '{29'h15555555, 29'h0AAAAAAA, 29'h1FFFFFFF, 1'b0};
        vecs[10] = '{29'h15555555, 29'h0AAAAAAB, 29'h00000000, 1'b1};
        vecs[11] = '{29'h1F0F0F0F, 29'h00F0F0F1, 29'h00000000, 1'b1};
        vecs[12] = '{29'h10000000, 29'h10000000, 29'h00000000, 1'b1};
        vecs[13] = '{29'h0F000000, 29'h01000000, 29'h10000000, 1'b0};
        vecs[14] = '{29'h12345678, 29'h0ABCDEF0, 29'h1CF13568, 1'b0};
        vecs[15] = '{29'h1FFFFF00, 29'h00000100, 29'h00000000, 1'b1};
        vecs[16] = '{29'h00FF00FF, 29'h00FF00FF, 29'h01FE01FE, 1'b0};
        vecs[17] = '{29'h1FFF0000, 29'h0001FFFF, 29'h0000FFFF, 1'b1};
        vecs[18] = '{29'h00000001, 29'h1FFFFFFF, 29'h00000000, 1'b1};
        vecs[19] = '{29'h1FFFF800, 29'h000007FF, 29'h1FFFFFFF, 1'b0};

        // Reset with all-ones operands present: they must be discarded.
        rst    = 1'b1;
        input1 = 29'h1FFFFFFF;
        input2 = 29'h1FFFFFFF;
        a8     = 8'h00;
        b8     = 8'h00;
        tick();
        check_all("reset", 29'h0, 1'b0);

        rst = 1'b0;
        tick();
        check_all("post_reset", 29'h1FFFFFFE, 1'b1);
        prev_s = 29'h1FFFFFFE;
        prev_c = 1'b1;

        // Back-to-back vectors with a mid-cycle glitch on the operands.
        for (int i = 0; i < 20; i++) begin
            input1 = vecs[i].a;
            input2 = vecs[i].b;
            #3;
            check($sformatf("latency_hold%0d", i), {carry_out, sum}, {prev_c, prev_s});
            input1 = ~vecs[i].a;
            input2 = ~vecs[i].b;
            #2;
            input1 = vecs[i].a;
            input2 = vecs[i].b;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].s, vecs[i].c);
            prev_s = vecs[i].s;
            prev_c = vecs[i].c;
        end

        // Operands held: outputs must not move.
        watch = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("idle%0d", i), {carry_out, sum}, {prev_c, prev_s});
        end
        watch = 1'b0;
        check("idle_toggles", toggles, 0);

        // Reset mid-stream, then immediate resume.
        input1 = 29'h12345678;
        input2 = 29'h0ABCDEF0;
        rst    = 1'b1;
        tick();
        check_all("mid_reset", 29'h0, 1'b0);
        rst = 1'b0;
        tick();
        check_all("resume", 29'h1CF13568, 1'b0);

        // Exhaustive 8-bit sweep against a behavioural addition.
        bad = 0;
        for (int i = 0; i < 65536; i++) begin
            a8 = i[15:8];
            b8 = i[7:0];
            tick();
            if ({c8, s8} !== ({1'b0, a8} + {1'b0, b8})) bad++;
        end
        check("n8_exhaustive_mismatches", bad, 0);
        check("n8_last", {c8, s8}, 9'h1FE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
